// File: rtl/apb_master_if.sv
`default_nettype none
// apb_master_if: single-outstanding APB master behind a req/gnt upstream port,
// with word-alignment check and an optional PREADY wait timeout.
module apb_master_if #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // The counter only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]                state;
  logic [CNT_W-1:0]          wait_cnt;
  logic                      we_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rdata_q;
  logic                      err_q;
  logic                      timeout_q;
  logic                      grant;
  logic                      aligned;
  logic                      timeout_hit;

  assign grant       = (state == IDLE) && req_i && !HRESET;
  assign aligned     = (addr_i[1:0] == 2'b00);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && !PREADY && (wait_cnt == TO_LIMIT);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Misaligned requests never reach the bus, so the APB-facing
          // request registers keep their previous contents.
          if (grant && aligned) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            state   <= SETUP;
          end else if (grant) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b0;
            state     <= RESP;
          end
        end
        SETUP: begin
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (!PREADY) wait_cnt <= wait_cnt + CNT_W'(1);
          if (PREADY) begin
            rdata_q   <= we_q ? 32'h0 : PRDATA;
            err_q     <= PSLVERR;
            timeout_q <= 1'b0;
            state     <= RESP;
          end else if (timeout_hit) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_o     = grant;
  assign rvalid_o  = (state == RESP);
  assign rdata_o   = rvalid_o ? rdata_q : 32'h0;
  assign err_o     = rvalid_o & err_q;
  assign timeout_o = rvalid_o & timeout_q;

  assign PSEL    = (state == SETUP) || (state == ACCESS);
  assign PENABLE = (state == ACCESS);
  assign PADDR   = addr_q;
  assign PWRITE  = we_q;
  assign PWDATA  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_if.sv
`default_nettype none
// tb_apb_master_if: table-driven directed checks of apb_master_if with a 4-cycle timeout.
module tb_apb_master_if;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_i, we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, err_o, timeout_o;
  logic [31:0] rdata_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  apb_master_if #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .timeout_o(timeout_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;   // PREADY-low ACCESS cycles before ready; 99 = never
    logic [31:0] prdata;
    logic        slverr;
    int          lat;     // cycles from grant to rvalid_o
    int          acc;     // expected ACCESS cycles
    logic        psel;    // expect PSEL to be seen
    logic        err;
    logic        to;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int k, acc, lat;
    logic got, psel_seen, hold_bad;
    logic [31:0] rd;
    logic er, to;
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata;
    PRDATA = v.prdata; PSLVERR = v.slverr; PREADY = 1'b0;
    #1;
    chk({v.name, " gnt"}, 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0;
    k = 1; acc = 0; got = 0; psel_seen = 0; hold_bad = 0;
    lat = -1; rd = '0; er = 0; to = 0;
    while (!got && k < 40) begin
      if (PSEL) begin
        psel_seen = 1;
        if (PADDR !== v.addr || PWRITE !== v.we || PWDATA !== v.wdata) hold_bad = 1;
      end
      if (PSEL && PENABLE) begin
        PREADY = (acc >= v.waits);
        acc++;
      end else begin
        PREADY = 1'b0;
      end
      if (rvalid_o) begin
        got = 1; lat = k; rd = rdata_o; er = err_o; to = timeout_o;
      end else begin
        tick();
        k++;
      end
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " access_cycles"}, 32'(acc), 32'(v.acc));
    chk({v.name, " psel_seen"}, 32'(psel_seen), 32'(v.psel));
    chk({v.name, " apb_hold"}, 32'(hold_bad), 32'd0);
    chk({v.name, " rdata"}, rd, v.rdata);
    chk({v.name, " err"}, 32'(er), 32'(v.err));
    chk({v.name, " timeout"}, 32'(to), 32'(v.to));
    PREADY = 1'b0;
    tick();
    chk({v.name, " rvalid_one_cycle"}, 32'(rvalid_o), 32'd0);
    chk({v.name, " psel_after"}, 32'(PSEL), 32'd0);
    chk({v.name, " outs_idle"}, {rdata_o[29:0], err_o, timeout_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"wr_zero_wait", 1'b1, 12'h010, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0,
                3, 1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{"rd_3_waits", 1'b0, 12'h020, 32'h1111_2222, 3, 32'h1234_5678, 1'b0,
                6, 4, 1'b1, 1'b0, 1'b0, 32'h1234_5678};
    vecs[2] = '{"wr_slverr", 1'b1, 12'h030, 32'h0BAD_0001, 0, 32'h7777_7777, 1'b1,
                3, 1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{"rd_timeout", 1'b0, 12'h040, 32'h0, 99, 32'hCAFE_F00D, 1'b0,
                6, 4, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{"rd_ready_at_limit", 1'b0, 12'h044, 32'h0, 3, 32'h55AA_55AA, 1'b0,
                6, 4, 1'b1, 1'b0, 1'b0, 32'h55AA_55AA};
    vecs[5] = '{"misaligned", 1'b1, 12'h013, 32'hFFFF_FFFF, 0, 32'h1357_9BDF, 1'b0,
                1, 0, 1'b0, 1'b1, 1'b0, 32'h0};

    HRESET = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 12'h010; wdata_i = 32'h1;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    chk("reset gnt", 32'(gnt_o), 32'd0);
    chk("reset apb_ctl", {PSEL, PENABLE, PWRITE}, 32'd0);
    chk("reset paddr", 32'(PADDR), 32'd0);
    chk("reset pwdata", PWDATA, 32'd0);
    chk("reset resp", {rvalid_o, err_o, timeout_o}, 32'd0);
    chk("reset rdata", rdata_o, 32'd0);
    HRESET = 1'b0; req_i = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of ACCESS, then grant on the first cycle after release.
    req_i = 1'b1; we_i = 1'b1; addr_i = 12'h050; wdata_i = 32'hFFFF_0000; PREADY = 1'b0;
    #1;
    chk("rst_mid gnt", 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0;
    tick();
    chk("rst_mid in_access", {PSEL, PENABLE}, 32'd3);
    #2;
    HRESET = 1'b1;
    req_i = 1'b1;
    #1;
    chk("rst_mid apb_ctl", {PSEL, PENABLE, PWRITE}, 32'd0);
    chk("rst_mid paddr", 32'(PADDR), 32'd0);
    chk("rst_mid pwdata", PWDATA, 32'd0);
    chk("rst_mid resp", {rvalid_o, err_o, timeout_o, gnt_o}, 32'd0);
    tick();
    chk("rst_mid no_rvalid", {rvalid_o, gnt_o}, 32'd0);
    HRESET = 1'b0; addr_i = 12'h060; we_i = 1'b0;
    #1;
    chk("rst_release gnt", 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0;
    chk("rst_release setup", {PSEL, PENABLE}, 32'd2);
    chk("rst_release paddr", 32'(PADDR), 32'h060);
    tick();
    PREADY = 1'b1; PRDATA = 32'h0F0F_A0A0;
    tick();
    PREADY = 1'b0;
    chk("rst_release rvalid", 32'(rvalid_o), 32'd1);
    chk("rst_release rdata", rdata_o, 32'h0F0F_A0A0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
